// File: rtl/mips_pip_cpu.sv
// mips_pip_cpu: 5-stage pipelined MIPS subset (IF, ID, EX, MEM, WB).
// Supports ADD/SUB/AND/OR/SLT, ADDI, LW, SW, BEQ, J and the all-zero NOP.
// Data hazards use EX/MEM and MEM/WB forwarding plus a one-cycle load-use stall.
// BEQ resolves in EX and J resolves in ID.
// Optional feature: define MIPS_EXCEPTION_EN to trap undefined instructions to EXC_ADDR.
// Without it, undefined instructions execute as NOPs.
module mips_pip_cpu #(
  parameter int MEM_SIZE = 512,
  parameter int EXC_ADDR = MEM_SIZE - 120
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic [31:0] RegisterNo,
  output logic [31:0] RegisterContent,
  output logic [31:0] DataAddr,
  output logic [31:0] Data
);

`ifdef MIPS_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] rf   [32];
  logic [31:0] dmem [64];

  // IF/ID
  logic [31:0] if_id_instr, if_id_pc4;

  // ID/EX
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
  logic        id_ex_alu_src, id_ex_branch;
  alu_op_t     id_ex_alu_op;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic [31:0] id_ex_rs_val, id_ex_rt_val, id_ex_imm, id_ex_pc4;

  // EX/MEM
  logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_alu, ex_mem_store;

  // MEM/WB
  logic        mem_wb_reg_write, mem_wb_mem_to_reg;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_alu, mem_wb_load;

  // ID fields and decoded controls
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_imm;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic        dec_alu_src, dec_branch, dec_jump, use_rs, use_rt, undefined;
  alu_op_t     dec_alu_op;
  logic [4:0]  dec_dest;
  logic [31:0] id_rs_val, id_rt_val;

  // Hazard and control-flow signals
  logic        load_use, exc_take, flush_if_id;
  logic [31:0] pc_next;

  // EX datapath
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result, branch_target;
  logic        branch_taken;

  // MEM/WB datapath
  logic        wb_we;
  logic [31:0] wb_data, mem_load;

  assign id_op    = if_id_instr[31:26];
  assign id_rs    = if_id_instr[25:21];
  assign id_rt    = if_id_instr[20:16];
  assign id_rd    = if_id_instr[15:11];
  assign id_shamt = if_id_instr[10:6];
  assign id_funct = if_id_instr[5:0];
  assign id_imm   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  assign wb_we    = mem_wb_reg_write && (mem_wb_dest != 5'd0);
  assign wb_data  = mem_wb_mem_to_reg ? mem_wb_load : mem_wb_alu;
  assign mem_load = dmem[ex_mem_alu[7:2]];

  // Decode the ID instruction into pipeline controls and flag undefined encodings
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_dest       = 5'd0;
    use_rs         = 1'b0;
    use_rt         = 1'b0;
    undefined      = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        if (if_id_instr != 32'd0) begin
          if (id_shamt != 5'd0) begin
            undefined = 1'b1;
          end else begin
            case (id_funct)
              F_ADD:   dec_alu_op = ALU_ADD;
              F_SUB:   dec_alu_op = ALU_SUB;
              F_AND:   dec_alu_op = ALU_AND;
              F_OR:    dec_alu_op = ALU_OR;
              F_SLT:   dec_alu_op = ALU_SLT;
              default: undefined  = 1'b1;
            endcase
          end
          if (!undefined) begin
            dec_reg_write = 1'b1;
            dec_dest      = id_rd;
            use_rs        = 1'b1;
            use_rt        = 1'b1;
          end
        end
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_dest      = id_rt;
        use_rs        = 1'b1;
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
        dec_dest       = id_rt;
        use_rs         = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        use_rs     = 1'b1;
        use_rt     = 1'b1;
      end
      OP_J:    dec_jump  = 1'b1;
      default: undefined = 1'b1;
    endcase
  end

  // Register file read with write-through from the instruction retiring this cycle
  always_comb begin
    id_rs_val = rf[id_rs];
    id_rt_val = rf[id_rt];
    if (wb_we && mem_wb_dest == id_rs) id_rs_val = wb_data;
    if (wb_we && mem_wb_dest == id_rt) id_rt_val = wb_data;
    if (id_rs == 5'd0) id_rs_val = 32'd0;
    if (id_rt == 5'd0) id_rt_val = 32'd0;
  end

  // EX operand forwarding (EX/MEM wins over MEM/WB), ALU and branch resolution
  always_comb begin
    fwd_a = id_ex_rs_val;
    fwd_b = id_ex_rt_val;
    if (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rs) fwd_a = ex_mem_alu;
    else if (wb_we && mem_wb_dest == id_ex_rs) fwd_a = wb_data;
    if (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rt) fwd_b = ex_mem_alu;
    else if (wb_we && mem_wb_dest == id_ex_rt) fwd_b = wb_data;
    alu_b = id_ex_alu_src ? id_ex_imm : fwd_b;
    case (id_ex_alu_op)
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_result = fwd_a + alu_b;
    endcase
    branch_taken  = id_ex_branch && (fwd_a == fwd_b);
    branch_target = id_ex_pc4 + {id_ex_imm[29:0], 2'b00};
  end

  // Hazard detection and next-PC selection; a taken branch overrides everything
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_dest != 5'd0) &&
               ((use_rs && id_rs == id_ex_dest) || (use_rt && id_rt == id_ex_dest));
    exc_take    = EXC_EN && undefined;
    flush_if_id = branch_taken || dec_jump || exc_take;
    if (branch_taken)  pc_next = branch_target;
    else if (load_use) pc_next = PC;
    else if (exc_take) pc_next = 32'(EXC_ADDR);
    else if (dec_jump) pc_next = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    else               pc_next = PC + 32'd4;
  end

  // PC and pipeline registers; reset turns every stage into a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      PC                <= 32'd0;
      if_id_instr       <= 32'd0;
      if_id_pc4         <= 32'd0;
      id_ex_reg_write   <= 1'b0;
      id_ex_mem_read    <= 1'b0;
      id_ex_mem_write   <= 1'b0;
      id_ex_mem_to_reg  <= 1'b0;
      id_ex_alu_src     <= 1'b0;
      id_ex_branch      <= 1'b0;
      id_ex_alu_op      <= ALU_ADD;
      id_ex_rs          <= 5'd0;
      id_ex_rt          <= 5'd0;
      id_ex_dest        <= 5'd0;
      id_ex_rs_val      <= 32'd0;
      id_ex_rt_val      <= 32'd0;
      id_ex_imm         <= 32'd0;
      id_ex_pc4         <= 32'd0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_dest       <= 5'd0;
      ex_mem_alu        <= 32'd0;
      ex_mem_store      <= 32'd0;
      mem_wb_reg_write  <= 1'b0;
      mem_wb_mem_to_reg <= 1'b0;
      mem_wb_dest       <= 5'd0;
      mem_wb_alu        <= 32'd0;
      mem_wb_load       <= 32'd0;
    end else begin
      PC <= pc_next;

      if (flush_if_id) begin
        if_id_instr <= 32'd0;
        if_id_pc4   <= 32'd0;
      end else if (!load_use) begin
        if_id_instr <= Instruction;
        if_id_pc4   <= PC + 32'd4;
      end

      if (branch_taken || load_use || exc_take) begin
        id_ex_reg_write  <= 1'b0;
        id_ex_mem_read   <= 1'b0;
        id_ex_mem_write  <= 1'b0;
        id_ex_mem_to_reg <= 1'b0;
        id_ex_alu_src    <= 1'b0;
        id_ex_branch     <= 1'b0;
        id_ex_alu_op     <= ALU_ADD;
        id_ex_rs         <= 5'd0;
        id_ex_rt         <= 5'd0;
        id_ex_dest       <= 5'd0;
        id_ex_rs_val     <= 32'd0;
        id_ex_rt_val     <= 32'd0;
        id_ex_imm        <= 32'd0;
        id_ex_pc4        <= 32'd0;
      end else begin
        id_ex_reg_write  <= dec_reg_write;
        id_ex_mem_read   <= dec_mem_read;
        id_ex_mem_write  <= dec_mem_write;
        id_ex_mem_to_reg <= dec_mem_to_reg;
        id_ex_alu_src    <= dec_alu_src;
        id_ex_branch     <= dec_branch;
        id_ex_alu_op     <= dec_alu_op;
        id_ex_rs         <= id_rs;
        id_ex_rt         <= id_rt;
        id_ex_dest       <= dec_dest;
        id_ex_rs_val     <= id_rs_val;
        id_ex_rt_val     <= id_rt_val;
        id_ex_imm        <= id_imm;
        id_ex_pc4        <= if_id_pc4;
      end

      ex_mem_reg_write  <= id_ex_reg_write;
      ex_mem_mem_read   <= id_ex_mem_read;
      ex_mem_mem_write  <= id_ex_mem_write;
      ex_mem_mem_to_reg <= id_ex_mem_to_reg;
      ex_mem_dest       <= id_ex_dest;
      ex_mem_alu        <= alu_result;
      ex_mem_store      <= fwd_b;

      mem_wb_reg_write  <= ex_mem_reg_write;
      mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
      mem_wb_dest       <= ex_mem_dest;
      mem_wb_alu        <= ex_mem_alu;
      mem_wb_load       <= mem_load;
    end
  end

  // Register file write at the end of WB; reset clears all registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_we) begin
      rf[mem_wb_dest] <= wb_data;
    end
  end

  // Data memory store in MEM; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && ex_mem_mem_write) dmem[ex_mem_alu[7:2]] <= ex_mem_store;
  end

  // Observation ports, forced to zero while reset is asserted
  always_comb begin
    RegisterNo      = 32'd0;
    RegisterContent = 32'd0;
    DataAddr        = 32'd0;
    Data            = 32'd0;
    if (!reset) begin
      if (wb_we) begin
        RegisterNo      = {27'd0, mem_wb_dest};
        RegisterContent = wb_data;
      end
      if (ex_mem_mem_read || ex_mem_mem_write) DataAddr = ex_mem_alu;
      if (ex_mem_mem_write)     Data = ex_mem_store;
      else if (ex_mem_mem_read) Data = mem_load;
    end
  end

endmodule

// File: tb/tb_mips_pip_cpu.sv
// tb_mips_pip_cpu: self-checking bench for mips_pip_cpu.
// Each scenario loads a program, pushes the register writes it must retire
// (register, value, cycle) to a scoreboard, and a monitor pops and compares
// every WB write the core reports.
module tb_mips_pip_cpu;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC, Instruction, RegisterNo, RegisterContent, DataAddr, Data;
  logic [31:0] imem [128];

  typedef struct {
    int          rno;
    logic [31:0] val;
    int          at;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc;

  mips_pip_cpu dut (
    .clk            (clk),
    .reset          (reset),
    .PC             (PC),
    .Instruction    (Instruction),
    .RegisterNo     (RegisterNo),
    .RegisterContent(RegisterContent),
    .DataAddr       (DataAddr),
    .Data           (Data)
  );

  assign Instruction = imem[PC[8:2]];

  always #5 clk = ~clk;

  // Cycle index since reset release: instruction k (no stalls) retires at cyc == k+4
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Scoreboard monitor: every reported WB write must match the next expected one
  always @(negedge clk) begin : wb_monitor
    wb_exp_t e;
    if (!reset && RegisterNo != 32'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL wb_unexpected: got r%0d=%h at cycle %0d, required no write",
                 RegisterNo, RegisterContent, cyc);
      end else begin
        e = exp_q.pop_front();
        if (RegisterNo !== 32'(e.rno) || RegisterContent !== e.val || cyc != e.at) begin
          errors++;
          $display("[TB] FAIL wb_write: got r%0d=%h at cycle %0d, required r%0d=%h at cycle %0d",
                   RegisterNo, RegisterContent, cyc, e.rno, e.val, e.at);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
  endtask

  task automatic begin_reset();
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (PC !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h, required 0", PC); end
    if (RegisterNo !== 32'd0) begin errors++; $display("[TB] FAIL reset_regno: got %h, required 0", RegisterNo); end
    if (RegisterContent !== 32'd0) begin errors++; $display("[TB] FAIL reset_regcontent: got %h, required 0", RegisterContent); end
    if (DataAddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_dataaddr: got %h, required 0", DataAddr); end
    if (Data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h, required 0", Data); end
    clear_imem();
    release_reset();
    step_to(3);
    checks++;
    if (PC !== 32'd12) begin errors++; $display("[TB] FAIL reset_pc_advance: got %h, required 0000000c", PC); end
  endtask

  task automatic test_addi();
    begin_reset();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 5, 5);
    exp_q.push_back('{5, 32'd5, 4});
    release_reset();
    step_to(2);
    checks++;
    if (PC !== 32'd8) begin errors++; $display("[TB] FAIL addi_pc: got %h, required 00000008", PC); end
    step_to(8);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL addi_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    begin_reset();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 3);
    imem[1] = enc_r(1, 1, 2, F_ADD);
    imem[2] = enc_r(2, 1, 3, F_SUB);
    exp_q.push_back('{1, 32'd3, 4});
    exp_q.push_back('{2, 32'd6, 5});
    exp_q.push_back('{3, 32'd3, 6});
    release_reset();
    step_to(6);
    checks++;
    if (PC !== 32'd24) begin errors++; $display("[TB] FAIL b2b_pc: got %h, required 00000018", PC); end
    step_to(9);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_load_use();
    begin_reset();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 5, 5);
    imem[1] = enc_i(OP_SW, 0, 5, 8);
    imem[2] = enc_i(OP_LW, 0, 6, 8);
    imem[3] = enc_r(6, 6, 7, F_ADD);
    exp_q.push_back('{5, 32'd5, 4});
    exp_q.push_back('{6, 32'd5, 6});
    exp_q.push_back('{7, 32'd10, 8});
    release_reset();
    step_to(4);
    checks += 2;
    if (DataAddr !== 32'd8) begin errors++; $display("[TB] FAIL sw_addr: got %h, required 00000008", DataAddr); end
    if (Data !== 32'd5) begin errors++; $display("[TB] FAIL sw_data: got %h, required 00000005", Data); end
    step_to(5);
    checks += 3;
    if (DataAddr !== 32'd8) begin errors++; $display("[TB] FAIL lw_addr: got %h, required 00000008", DataAddr); end
    if (Data !== 32'd5) begin errors++; $display("[TB] FAIL lw_data: got %h, required 00000005", Data); end
    if (PC !== 32'd16) begin errors++; $display("[TB] FAIL stall_pc: got %h, required 00000010", PC); end
    step_to(6);
    checks += 2;
    if (DataAddr !== 32'd0) begin errors++; $display("[TB] FAIL bubble_addr: got %h, required 0", DataAddr); end
    if (PC !== 32'd20) begin errors++; $display("[TB] FAIL resume_pc: got %h, required 00000014", PC); end
    step_to(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL loaduse_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_branch();
    begin_reset();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 1);
    imem[1] = enc_i(OP_BEQ, 0, 0, 2);
    imem[2] = enc_i(OP_ADDI, 0, 2, 2);
    imem[3] = enc_i(OP_ADDI, 0, 3, 3);
    imem[4] = enc_i(OP_ADDI, 0, 4, 4);
    imem[5] = enc_i(OP_BEQ, 1, 0, 5);
    imem[6] = enc_i(OP_ADDI, 0, 6, 6);
    exp_q.push_back('{1, 32'd1, 4});
    exp_q.push_back('{4, 32'd4, 8});
    exp_q.push_back('{6, 32'd6, 10});
    release_reset();
    step_to(3);
    checks++;
    if (PC !== 32'd12) begin errors++; $display("[TB] FAIL beq_pc_before: got %h, required 0000000c", PC); end
    step_to(4);
    checks++;
    if (PC !== 32'd16) begin errors++; $display("[TB] FAIL beq_target: got %h, required 00000010", PC); end
    step_to(7);
    checks++;
    if (PC !== 32'd28) begin errors++; $display("[TB] FAIL beq_not_taken_pc: got %h, required 0000001c", PC); end
    step_to(12);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL branch_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_jump();
    begin_reset();
    clear_imem();
    imem[0]  = enc_j(10);
    imem[1]  = enc_i(OP_ADDI, 0, 1, 1);
    imem[10] = enc_i(OP_ADDI, 0, 2, 7);
    imem[11] = enc_r(2, 2, 3, F_ADD);
    exp_q.push_back('{2, 32'd7, 6});
    exp_q.push_back('{3, 32'd14, 7});
    release_reset();
    step_to(2);
    checks++;
    if (PC !== 32'd40) begin errors++; $display("[TB] FAIL jump_target: got %h, required 00000028", PC); end
    step_to(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL jump_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_alu();
    begin_reset();
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 0, 1, -3);
    imem[1]  = enc_i(OP_ADDI, 0, 2, 5);
    imem[2]  = enc_r(1, 2, 3, F_SLT);
    imem[3]  = enc_r(2, 1, 4, F_SLT);
    imem[4]  = enc_r(1, 2, 5, F_AND);
    imem[5]  = enc_r(1, 2, 6, F_OR);
    imem[6]  = enc_r(2, 1, 7, F_SUB);
    imem[7]  = enc_r(1, 1, 8, F_ADD);
    imem[8]  = enc_i(OP_ADDI, 0, 9, -1);
    imem[9]  = enc_i(OP_ADDI, 9, 10, 1);
    imem[10] = enc_i(OP_ADDI, 0, 0, 9);
    imem[11] = enc_r(0, 0, 11, F_ADD);
    imem[12] = enc_r(0, 2, 12, F_SUB);
    exp_q.push_back('{1,  32'hFFFF_FFFD, 4});
    exp_q.push_back('{2,  32'd5,         5});
    exp_q.push_back('{3,  32'd1,         6});
    exp_q.push_back('{4,  32'd0,         7});
    exp_q.push_back('{5,  32'd5,         8});
    exp_q.push_back('{6,  32'hFFFF_FFFD, 9});
    exp_q.push_back('{7,  32'd8,         10});
    exp_q.push_back('{8,  32'hFFFF_FFFA, 11});
    exp_q.push_back('{9,  32'hFFFF_FFFF, 12});
    exp_q.push_back('{10, 32'd0,         13});
    exp_q.push_back('{11, 32'd0,         15});
    exp_q.push_back('{12, 32'hFFFF_FFFB, 16});
    release_reset();
    step_to(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL alu_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_undefined();
    begin_reset();
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 0, 1, 1);
    imem[1]  = enc_i(OP_ADDI, 0, 2, 2);
    imem[2]  = 32'hFC00_0000;
    imem[3]  = enc_i(OP_ADDI, 0, 3, 3);
    imem[98] = enc_i(OP_ADDI, 0, 9, 9);
    exp_q.push_back('{1, 32'd1, 4});
    exp_q.push_back('{2, 32'd2, 5});
`ifdef MIPS_EXCEPTION_EN
    exp_q.push_back('{9, 32'd9, 8});
`else
    exp_q.push_back('{3, 32'd3, 7});
`endif
    release_reset();
    step_to(3);
    checks++;
    if (PC !== 32'd12) begin errors++; $display("[TB] FAIL undef_pc_before: got %h, required 0000000c", PC); end
    step_to(4);
    checks++;
`ifdef MIPS_EXCEPTION_EN
    if (PC !== 32'd392) begin errors++; $display("[TB] FAIL undef_pc_vector: got %h, required 00000188", PC); end
`else
    if (PC !== 32'd16) begin errors++; $display("[TB] FAIL undef_pc_seq: got %h, required 00000010", PC); end
`endif
    step_to(12);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL undef_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    begin_reset();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 77);
    imem[1] = enc_i(OP_SW, 0, 1, 12);
    imem[2] = enc_i(OP_LW, 0, 6, 12);
    imem[3] = enc_r(6, 6, 7, F_ADD);
    imem[4] = enc_i(OP_SW, 0, 7, 12);
    exp_q.push_back('{1, 32'd77, 4});
    release_reset();
    step_to(5);
    checks += 3;
    if (DataAddr !== 32'd12) begin errors++; $display("[TB] FAIL mid_lw_addr: got %h, required 0000000c", DataAddr); end
    if (Data !== 32'd77) begin errors++; $display("[TB] FAIL mid_lw_data: got %h, required 0000004d", Data); end
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL mid_pending: got %0d writes missing, required 0", exp_q.size()); end
    #1 reset = 1'b1;
    #1;
    checks += 2;
    if (DataAddr !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_addr: got %h, required 0", DataAddr); end
    if (Data !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_data: got %h, required 0", Data); end
    @(negedge clk);
    checks += 3;
    if (PC !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_pc: got %h, required 0", PC); end
    if (RegisterNo !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_regno: got %h, required 0", RegisterNo); end
    if (RegisterContent !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_regcontent: got %h, required 0", RegisterContent); end
    clear_imem();
    imem[0] = enc_i(OP_LW, 0, 8, 12);
    imem[1] = enc_r(1, 1, 9, F_ADD);
    imem[2] = enc_r(8, 0, 10, F_ADD);
    exp_q.push_back('{8,  32'd77, 4});
    exp_q.push_back('{9,  32'd0,  5});
    exp_q.push_back('{10, 32'd77, 6});
    release_reset();
    step_to(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL post_reset_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  initial begin
    clear_imem();
    $display("[TB] starting mips_pip_cpu bench");
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_jump();
    test_alu();
    test_undefined();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pip_cpu.md
MIPS_PIP_CPU -- requirements
Module: mips_pip_cpu

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512: instruction address space in bytes.
REQ-002 SHALL have parameter EXC_ADDR, default MEM_SIZE-120 (392): exception vector, the last 30 instruction slots.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port PC, output, 32 bits: current fetch address, byte-addressed.
REQ-006 SHALL have port Instruction, input, 32 bits: word at PC, supplied combinationally by external instruction memory.
REQ-007 SHALL have port RegisterNo, output, 32 bits: zero-extended destination register of the instruction retiring in WB, else 0.
REQ-008 SHALL have port RegisterContent, output, 32 bits: value written in WB, else 0.
REQ-009 SHALL have port DataAddr, output, 32 bits: MEM-stage data address for LW/SW, else 0.
REQ-010 SHALL have port Data, output, 32 bits: MEM-stage store data for SW, load data for LW, else 0.

Function
REQ-011 SHALL implement a 5-stage pipeline (IF, ID, EX, MEM, WB) with one instruction issued per cycle when no stall occurs.
REQ-012 SHALL support ADD, SUB, AND, OR, SLT (R-type, funct 0x20/0x22/0x24/0x25/0x2A), ADDI (0x08, sign-extended immediate), LW (0x23), SW (0x2B), BEQ (0x04), J (0x02), and all-zero NOP.
REQ-013 SHALL use 32-bit wrap-around arithmetic with no overflow trap; SLT SHALL be a signed comparison.
REQ-014 SHALL hold a 32x32 register file with r0 hard-wired to 0; writes to r0 are discarded.
REQ-015 SHALL write the register file on the rising edge ending WB, and an ID read of the same register in that cycle SHALL return the new value.
REQ-016 SHALL hold 64 words of internal data memory, word-addressed by address bits [7:2]; higher address bits are ignored.
REQ-017 SHALL forward operands to EX from EX/MEM (priority) and from MEM/WB; no forwarding for r0.
REQ-018 SHALL stall IF/ID for exactly one cycle and insert a bubble when an ID instruction reads the destination of an LW in EX.
REQ-019 SHALL resolve BEQ in EX: if taken, set PC to PC_beq+4+(signext(imm)<<2) and flush IF/ID and ID/EX (2-cycle penalty); if not taken, no penalty.
REQ-020 SHALL resolve J in ID: set PC to {PC+4[31:28], target, 2'b00} and flush IF/ID (1-cycle penalty).
REQ-021 SHALL give a taken branch in EX priority over a J in ID and over a load-use stall in the same cycle.
REQ-022 SHALL make PC advance by 4 and wrap modulo 2^32.
REQ-023 SHALL retire an ADDI fetched in the first cycle after reset release so its result is in the register file after the 5th following rising edge.

Reset
REQ-024 While reset=1 at a rising edge: PC=0, all pipeline registers become bubbles, register file cleared to 0, stall and flush state cleared.
REQ-025 While in reset, RegisterNo, RegisterContent, DataAddr and Data SHALL read 0; data memory contents SHALL be preserved.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight instructions without any register or memory write in that cycle.

Configuration
REQ-027 With macro MIPS_EXCEPTION_EN defined, an undefined opcode/funct in ID SHALL become a bubble, flush IF/ID, and load PC with EXC_ADDR at the next edge; older instructions complete.
REQ-028 Without MIPS_EXCEPTION_EN, an undefined instruction SHALL execute as a NOP and PC SHALL continue sequentially.

Verification
REQ-029 Scenario: reset for 2 cycles, then ADDI r5,r0,5 at address 0 -> regfile[5]=5 within 5 cycles after release; RegisterNo=5 and RegisterContent=5 in its WB cycle.
REQ-030 Scenario: ADDI r1,r0,3; ADD r2,r1,r1; SUB r3,r2,r1 back-to-back -> r2=6, r3=3, no stall cycles.
REQ-031 Scenario: SW r5,8(r0) then LW r6,8(r0); ADD r7,r6,r6 -> exactly one stall, r7=10; DataAddr=8 during both MEM cycles.
REQ-032 Scenario: BEQ r0,r0,+2 at address 4 -> next executed instruction at 16; the two instructions after the BEQ write nothing.
REQ-033 Scenario: opcode 0x3F at address 8 with MIPS_EXCEPTION_EN -> PC=392 after the flush; without it -> PC continues to 12, no register write.
REQ-034 Scenario: assert reset while LW/ADD are in flight -> PC=0, all outputs 0, no register write, memory unchanged.
